// File: rtl/md_pkg.sv
// Shared encodings for the multiply/divide scheduler and its divider core.
package md_pkg;

  localparam int MD_W = 32;

  localparam logic [3:0] OP_NONE  = 4'd0;
  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2
  } md_state_e;

  function automatic logic is_long_op(input logic [3:0] op);
    return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/md_div_core.sv
// Unsigned restoring divider, one quotient bit per step. Outputs show the
// quotient/remainder as they will be after the current cycle's step.
module md_div_core
  import md_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic            step,
  input  logic [MD_W-1:0] dividend,
  input  logic [MD_W-1:0] divisor,
  output logic [MD_W-1:0] quotient,
  output logic [MD_W-1:0] remainder
);

  logic [MD_W-1:0] quo_q, quo_d;
  logic [MD_W-1:0] rem_q, rem_d;
  logic [MD_W-1:0] dsr_q, dsr_d;
  logic [MD_W:0]   rem_sh;
  logic [MD_W:0]   diff;
  logic            q_bit;

  always_comb begin
    rem_sh = {rem_q, quo_q[MD_W-1]};
    diff   = rem_sh - {1'b0, dsr_q};
    q_bit  = ~diff[MD_W];
    quotient  = {quo_q[MD_W-2:0], q_bit};
    remainder = q_bit ? diff[MD_W-1:0] : rem_sh[MD_W-1:0];
  end

  always_comb begin
    quo_d = quo_q;
    rem_d = rem_q;
    dsr_d = dsr_q;
    if (load) begin
      quo_d = dividend;
      rem_d = '0;
      dsr_d = divisor;
    end else if (step) begin
      quo_d = quotient;
      rem_d = remainder;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      quo_q <= '0;
      rem_q <= '0;
      dsr_q <= '0;
    end else begin
      quo_q <= quo_d;
      rem_q <= rem_d;
      dsr_q <= dsr_d;
    end
  end

endmodule

// File: rtl/md_sched.sv
// Multi-cycle MULT/DIV scheduler owning HI/LO; raises the pipeline stall.
//   state   | meaning
//   ST_IDLE | ready for an op; MTHI/MTLO complete here in one edge
//   ST_MUL  | product held in shadow reg, counting down fixed latency
//   ST_DIV  | divider stepping one quotient bit per cycle
module md_sched
  import md_pkg::*;
#(
  parameter int MULT_LAT = 5,
  parameter int DIV_ITER = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [3:0]      op,
  input  logic [MD_W-1:0] a,
  input  logic [MD_W-1:0] b,
  input  logic            cancel,
  input  logic            id_md_use,
  output logic            busy,
  output logic            stall,
  output logic            done,
  output logic [MD_W-1:0] hi,
  output logic [MD_W-1:0] lo,
  output logic [MD_W-1:0] rdata
);

  localparam int MAX_LAT = (MULT_LAT > DIV_ITER) ? MULT_LAT : DIV_ITER;
  localparam int CNT_W   = ($clog2(MAX_LAT) < 1) ? 1 : $clog2(MAX_LAT);

  md_state_e          state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [MD_W-1:0]    hi_q, hi_d;
  logic [MD_W-1:0]    lo_q, lo_d;
  logic [2*MD_W-1:0]  prod_q, prod_d;
  logic               neg_quo_q, neg_quo_d;
  logic               neg_rem_q, neg_rem_d;
  logic               dz_q, dz_d;
  logic               done_q, done_d;

  logic               is_signed;
  logic [2*MD_W-1:0]  ext_a, ext_b;
  logic [MD_W-1:0]    a_mag, b_mag;
  logic               div_load, div_step;
  logic [MD_W-1:0]    div_quo, div_rem;

  // One multiplier serves both signednesses: extend to 64 bits, keep low half.
  always_comb begin
    is_signed = (op == OP_MULT) || (op == OP_DIV);
    ext_a = is_signed ? {{MD_W{a[MD_W-1]}}, a} : {{MD_W{1'b0}}, a};
    ext_b = is_signed ? {{MD_W{b[MD_W-1]}}, b} : {{MD_W{1'b0}}, b};
    a_mag = (is_signed && a[MD_W-1]) ? (~a + 1'b1) : a;
    b_mag = (is_signed && b[MD_W-1]) ? (~b + 1'b1) : b;
  end

  md_div_core u_div (
    .clk       (clk),
    .rst_n     (reset),
    .load      (div_load),
    .step      (div_step),
    .dividend  (a_mag),
    .divisor   (b_mag),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    prod_d    = prod_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    dz_d      = dz_q;
    done_d    = 1'b0;
    div_load  = 1'b0;
    div_step  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start && !cancel) begin
          case (op)
            OP_MULT, OP_MULTU: begin
              prod_d  = ext_a * ext_b;
              state_d = ST_MUL;
              cnt_d   = CNT_W'(MULT_LAT - 1);
            end
            OP_DIV, OP_DIVU: begin
              div_load  = 1'b1;
              neg_quo_d = is_signed && (a[MD_W-1] ^ b[MD_W-1]);
              neg_rem_d = is_signed && a[MD_W-1];
              dz_d      = (b == '0);
              state_d   = ST_DIV;
              cnt_d     = CNT_W'(DIV_ITER - 1);
            end
            OP_MTHI: hi_d = a;
            OP_MTLO: lo_d = a;
            default: ;
          endcase
        end
      end

      ST_MUL: begin
        if (cancel) begin
          state_d = ST_IDLE;
        end else if (cnt_q == '0) begin
          {hi_d, lo_d} = prod_q;
          state_d      = ST_IDLE;
          done_d       = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      ST_DIV: begin
        if (cancel) begin
          state_d = ST_IDLE;
        end else begin
          div_step = 1'b1;
          if (cnt_q == '0) begin
            // Divide by zero still burns the full latency but keeps HI/LO.
            if (!dz_q) begin
              lo_d = neg_quo_q ? (~div_quo + 1'b1) : div_quo;
              hi_d = neg_rem_q ? (~div_rem + 1'b1) : div_rem;
            end
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      prod_q    <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dz_q      <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      prod_q    <= prod_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      dz_q      <= dz_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    case (op)
      OP_MFHI: rdata = hi_q;
      OP_MFLO: rdata = lo_q;
      default: rdata = '0;
    endcase
  end

  assign busy  = (state_q != ST_IDLE);
  assign stall = id_md_use & (busy | (start & is_long_op(op)));
  assign done  = done_q;
  assign hi    = hi_q;
  assign lo    = lo_q;

endmodule

// File: doc/md_sched.md
Name: md_sched

Overview:
- Multi-cycle multiply/divide scheduler for the 5-stage core; owns the HI/LO registers.
- Accepts one MD operation per start pulse from EX.
- Runs multiply with a fixed latency and divide iteratively, one quotient bit per cycle.
- Raises the stall that freezes IF/ID/EX while an MD-dependent instruction waits in ID.

Parameters:
MULT_LAT, 5, busy cycles for MULT/MULTU (must be ≥1)
DIV_ITER, 32, busy cycles for DIV/DIVU (one bit per cycle)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
start  in  1  operation issue strobe from EX
op  in  4  operation code (md_pkg encoding)
a  in  32  rs operand (forwarded)
b  in  32  rt operand (forwarded)
cancel  in  1  abort in-flight MULT/DIV
id_md_use  in  1  instruction in ID is an MD op (mult/div/mf/mt)
busy  out  1  operation in flight
stall  out  1  pipeline freeze request
done  out  1  one-cycle commit pulse
hi  out  32  HI register
lo  out  32  LO register
rdata  out  32  MFHI→hi, MFLO→lo, otherwise 0 (combinational on op)

Behaviour:
- Reset (reset=0, async): state=IDLE, counter=0, hi=lo=0, busy=0, done=0. Takes effect immediately, including mid-operation.
- States: IDLE, MUL, DIV.
- IDLE, start=1 at edge T0:
  - MULT/MULTU: 64-bit product of a×b captured into a shadow register; state→MUL; cnt=MULT_LAT-1.
  - DIV/DIVU: operands latched as magnitudes plus sign flags; remainder cleared; state→DIV; cnt=DIV_ITER-1.
  - MTHI/MTLO: hi or lo ← a on edge T0; stay IDLE; no busy, no done.
  - MFHI/MFLO/NONE: no state change.
- busy = (state≠IDLE). It is high in cycles T0+1 … T0+LAT, where LAT is MULT_LAT or DIV_ITER.
- MUL: cnt decrements each cycle. On the edge ending the cycle with cnt=0: {hi,lo} ← product, state→IDLE, done=1 for one cycle. Busy is low and the new hi/lo are visible in the same cycle.
- DIV: one restoring shift-subtract step per cycle in md_div_core. On the edge ending the cycle with cnt=0, apply sign fixup and commit:
  - lo ← quotient, truncated toward zero.
  - hi ← remainder, sign taken from the dividend.
  - state→IDLE; done=1.
- Divide by zero: full DIV_ITER busy cycles still run; done still pulses; hi/lo left unchanged.
- Signed 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0.
- start while busy: ignored; in-flight operation is unaffected.
- cancel=1 at an edge while busy: state→IDLE, hi/lo unchanged, no done; busy is 0 next cycle.
- cancel and start at the same edge in IDLE: start is ignored.
- stall = id_md_use & (busy | (start & op∈{MULT,MULTU,DIV,DIVU})). Combinational; deasserts in the first cycle busy=0.
- MFHI/MFLO are issued only when not stalled, so rdata is always read from committed hi/lo.

Decomposition:
- md_pkg holds:
  - op encodings: NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MFHI=5, MFLO=6, MTHI=7, MTLO=8
  - state enum {IDLE, MUL, DIV}
  - MD_W=32
- Sub-module md_div_core: unsigned restoring divider.
  - Inputs: load, step, dividend, divisor.
  - Outputs: quotient, remainder.
  - Sign handling stays in md_sched.

Test Plan:
1. MULT a=0xFFFFFFFE, b=3 → busy for exactly 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA; a single done pulse.
2. MULTU a=0xFFFFFFFE, b=3 → hi=0x00000002, lo=0xFFFFFFFA. MTHI a=0x1234 → hi=0x1234 next cycle, busy stays 0.
3. DIV a=0xFFFFFFF9 (-7), b=2 → busy 32 cycles; lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU a=7, b=2 → lo=3, hi=1. DIV 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0.
4. Preload hi=0xAAAA, lo=0x5555; DIV b=0 → 32 busy cycles, done pulses, hi/lo unchanged.
5. id_md_use=1 held from the start cycle through a MULT → stall=1 for 6 cycles (start cycle plus 5 busy), drops with busy. A second start mid-busy → ignored, result matches the first operation.
6. cancel at DIV busy cycle 10 → busy=0 next cycle, hi/lo unchanged, no done. reset=0 during a MULT → busy=0 and hi=lo=0 without a clock edge.
